// File: rtl/apb_cmd_master_if.sv
// Bundle of the command/response stream and the APB4 requester bus seen by
// apb_cmd_master. The master modport is the requester's view; the slave
// modport is the view of whatever sits on the other side (shim plus timer).
interface apb_cmd_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  // Response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB4 bus
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 requester: turns one valid/ready command into one APB transfer
// (SETUP then ACCESS), with an optional wait-state limit, and returns the
// result on a valid/ready response channel. One transfer in flight at a time.
module apb_cmd_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // ACCESS cycles with pready=0 before abort; 0 = never
) (
  input logic                sys_clk,
  input logic                sys_rst,
  apb_cmd_master_if.master   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              run_q;          // low during reset and until the first edge after it
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              cmd_ready;
  logic              psel;
  logic              penable;

  // Next-state, captured command, wait counter, response and bus controls.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready     = run_q && (state_q == IDLE) && !rsp_valid_q;
    psel          = 1'b0;
    penable       = 1'b0;

    // A consumed response clears; it can never coincide with a completion
    // because no command is accepted while a response is pending.
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_ready && bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : '0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (bus.pready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    if (sys_rst) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel;
  assign bus.penable     = penable;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a 4-cycle wait-state limit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_cmd_master;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one command and play the APB slave: pready rises on ACCESS cycle
  // number waits (0-based); waits < 0 never raises it.
  task automatic do_xfer(input string tag, input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                         input logic err, input logic [31:0] rdata,
                         output int lat, output int psel_cyc, output int pen_cyc);
    int   acc;
    logic bus_ok;
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    step();
    bus.cmd_valid = 1'b0;
    lat = 0; psel_cyc = 0; pen_cyc = 0; acc = 0; bus_ok = 1'b1;
    while (!bus.rsp_valid && lat < 50) begin
      bus.pready = 1'b0;
      if (bus.psel) begin
        psel_cyc++;
        if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata ||
            bus.pstrb !== (wr ? strb : 4'h0))
          bus_ok = 1'b0;
      end
      if (bus.penable) begin
        pen_cyc++;
        bus.pready  = (acc == waits);
        bus.pslverr = err;
        bus.prdata  = rdata;
        acc++;
      end
      step();
      lat++;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    check({tag, "_bus_stable"}, bus_ok, 1);
    check({tag, "_psel_after"}, bus.psel, 0);
    check({tag, "_penable_after"}, bus.penable, 0);
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_cleared"}, bus.rsp_valid, 0);
    check({tag, "_ready_again"}, bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat, ps, pe;
    logic hold_ok;
    logic [31:0] snap_rdata;
    logic snap_err, snap_tmo;

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_strb  = '0;   bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0; bus.pslverr   = 1'b0; bus.prdata    = '0;

    // Reset state
    repeat (2) step();
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_paddr", bus.paddr, 0);
    sys_rst = 1'b0;
    #1;
    check("ready_before_first_edge", bus.cmd_ready, 0);
    step();
    check("ready_after_first_edge", bus.cmd_ready, 1);

    // Zero-wait write
    do_xfer("wr0", 1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'hFFFF_FFFF, lat, ps, pe);
    check("wr0_lat", lat, 2);
    check("wr0_psel_cycles", ps, 2);
    check("wr0_penable_cycles", pe, 1);
    check("wr0_err", bus.rsp_err, 0);
    check("wr0_timeout", bus.rsp_timeout, 0);
    check("wr0_rdata", bus.rsp_rdata, 0);
    handshake("wr0");

    // Read with 3 wait states (pready on the last allowed ACCESS cycle)
    do_xfer("rd3", 1'b0, 12'h010, 32'h5555_AAAA, 4'hC, 3, 1'b0, 32'h1234_5678, lat, ps, pe);
    check("rd3_lat", lat, 5);
    check("rd3_penable_cycles", pe, 4);
    check("rd3_rdata", bus.rsp_rdata, 32'h1234_5678);
    check("rd3_err", bus.rsp_err, 0);
    check("rd3_timeout", bus.rsp_timeout, 0);
    handshake("rd3");

    // Write with slave error
    do_xfer("wrerr", 1'b1, 12'h008, 32'h0000_00FF, 4'h1, 1, 1'b1, 32'h0, lat, ps, pe);
    check("wrerr_lat", lat, 3);
    check("wrerr_err", bus.rsp_err, 1);
    check("wrerr_timeout", bus.rsp_timeout, 0);
    handshake("wrerr");

    // Wait-state timeout: pready never comes
    do_xfer("tmo", 1'b0, 12'h020, 32'h0BAD_0BAD, 4'hF, -1, 1'b0, 32'hDEAD_BEEF, lat, ps, pe);
    check("tmo_lat", lat, 5);
    check("tmo_penable_cycles", pe, 4);
    check("tmo_psel_cycles", ps, 5);
    check("tmo_err", bus.rsp_err, 1);
    check("tmo_timeout", bus.rsp_timeout, 1);
    check("tmo_rdata", bus.rsp_rdata, 0);
    handshake("tmo");

    // Response back-pressure: pending write response, new command waiting
    do_xfer("bp", 1'b1, 12'h00C, 32'h0000_0042, 4'h3, 0, 1'b1, 32'h0, lat, ps, pe);
    snap_rdata = bus.rsp_rdata;
    snap_err   = bus.rsp_err;
    snap_tmo   = bus.rsp_timeout;
    check("bp_err", snap_err, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h030;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_rdata !== snap_rdata || bus.rsp_err !== snap_err || bus.rsp_timeout !== snap_tmo)
        hold_ok = 1'b0;
    end
    check("bp_hold_stable", hold_ok, 1);
    handshake("bp");
    do_xfer("bprd", 1'b0, 12'h030, 32'h0, 4'h0, 0, 1'b0, 32'h0000_BEEF, lat, ps, pe);
    check("bprd_lat", lat, 2);
    check("bprd_rdata", bus.rsp_rdata, 32'h0000_BEEF);
    handshake("bprd");

    // Reset in the middle of ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h040;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("mid_in_access", bus.penable, 1);
    step();
    sys_rst = 1'b1;
    #1;
    check("mid_rst_psel", bus.psel, 0);
    check("mid_rst_penable", bus.penable, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    step();
    sys_rst = 1'b0;
    step();
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    do_xfer("postrd", 1'b0, 12'h044, 32'h0, 4'h0, 1, 1'b0, 32'hCAFE_F00D, lat, ps, pe);
    check("postrd_lat", lat, 3);
    check("postrd_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    check("postrd_err", bus.rsp_err, 0);
    handshake("postrd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
